// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through a newd/donetx handshake.
// Host bytes enter over valid/ready and are buffered in a circular store.
// One byte at a time is moved into a hold register and offered to the transmitter.
// The byte is held there until the transmitter signals frame completion.
// Optional feature macro: UART_TXQ_STATS_EN adds a 16-bit count of completed frames (tx_count).
module uart_tx_queue #(
   parameter int DEPTH = 16,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          newd,
   output logic [7:0]    dintx,
   input  logic          donetx,
   output logic [LW-1:0] level,
   output logic          empty,
   output logic          full,
   output logic          busy
`ifdef UART_TXQ_STATS_EN
   ,
   output logic [15:0]   tx_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
   localparam logic [AW-1:0] PTR_ZERO   = AW'(1'b0);
   localparam logic [LW-1:0] LEVEL_ONE  = LW'(1'b1);
   localparam logic [LW-1:0] LEVEL_ZERO = LW'(1'b0);
   localparam logic [LW-1:0] LEVEL_MAX  = LW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [LW-1:0] level_r;
   logic [LW-1:0] level_s;
   logic          empty_r;
   logic          full_r;
   logic          donetx_q_r;
   logic [7:0]    dintx_r;
   logic          newd_r;
   logic          busy_r;
   logic          push_s;
   logic          pop_s;
   logic          done_rise_s;
   logic          in_ready_s;

   // full is registered, so in_ready never depends on a same-cycle pop
   assign in_ready_s  = rst & ~full_r;
   assign push_s      = in_valid & in_ready_s;
   assign done_rise_s = donetx & ~donetx_q_r;

   assign in_ready = in_ready_s;
   assign newd     = newd_r;
   assign dintx    = dintx_r;
   assign level    = level_r;
   assign empty    = empty_r;
   assign full     = full_r;
   assign busy     = busy_r;

   // Next-state logic; the pop happens on the edge that enters LOAD
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_r) begin
               state_s = ST_LOAD;
               pop_s   = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_s = ST_SEND;
         end
         ST_SEND: begin
            // completion is only meaningful while a byte is being offered
            if (done_rise_s) begin
               state_s = ST_GAP;
            end else begin
               state_s = ST_SEND;
            end
         end
         ST_GAP: begin
            if (!empty_r) begin
               state_s = ST_LOAD;
               pop_s   = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Occupancy update; a simultaneous push and pop leaves it unchanged
   always_comb begin
      level_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_s = level_r + LEVEL_ONE;
         2'b01:   level_s = level_r - LEVEL_ONE;
         default: level_s = level_r;
      endcase
   end

   // Storage write port; pointers and level define which entries are valid, so no reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Control state, pointers, flags and registered transmitter-side outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LEVEL_ZERO;
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         donetx_q_r <= 1'b0;
         dintx_r    <= 8'h00;
         newd_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         donetx_q_r <= donetx;
         level_r    <= level_s;
         empty_r    <= (level_s == LEVEL_ZERO);
         full_r     <= (level_s == LEVEL_MAX);
         newd_r     <= (state_s == ST_SEND);
         busy_r     <= (state_s != ST_IDLE);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            dintx_r  <= mem_r[rd_ptr_r];
         end
      end
   end

`ifdef UART_TXQ_STATS_EN
   logic [15:0] tx_count_r;

   assign tx_count = tx_count_r;

   // Completed-frame counter; wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_count_r <= 16'h0000;
      end else if ((state_r == ST_SEND) && done_rise_s) begin
         tx_count_r <= tx_count_r + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: accepted bytes are queued as expectations,
// a behavioural transmitter model consumes newd/dintx and checks them in order.
module tb_uart_tx_queue;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          newd;
   logic [7:0]    dintx;
   logic          donetx;
   logic [LW-1:0] level;
   logic          empty;
   logic          full;
   logic          busy;
`ifdef UART_TXQ_STATS_EN
   logic [15:0]   tx_count;
`endif

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   logic stall = 1'b0;
   int spur_cnt = 0;
   int spur_done = 0;
   int rst_cnt = 0;
   int sent_count = 0;
   logic tx_busy = 1'b0;

   uart_tx_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .newd(newd), .dintx(dintx), .donetx(donetx), .level(level), .empty(empty),
      .full(full), .busy(busy)
`ifdef UART_TXQ_STATS_EN
      , .tx_count(tx_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Offer one byte (starting at a negedge); record it as expected once accepted
   task automatic push_byte(input logic [7:0] b);
      int n = 0;
      bit done_l = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      while (!done_l) begin
         bit rdy;
         rdy = in_ready;
         @(posedge clk);
         if (rdy) begin
            exp_q.push_back(b);
            done_l = 1'b1;
         end else begin
            n++;
            if (n > 3000) begin
               total++;
               bad++;
               $display("FAIL push_timeout: byte %0h never accepted", b);
               done_l = 1'b1;
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // Wait until every expected byte has left and both sides are idle
   task automatic wait_drain();
      int n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && busy == 1'b0 && tx_busy == 1'b0 && empty == 1'b1) && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 6000) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: queue=%0d busy=%0b", exp_q.size(), busy);
      end
   endtask

   // Behavioural transmitter: takes a byte when idle and newd is high, completes it later
   initial begin : tx_model
      logic [7:0] cap;
      int rc;
      donetx = 1'b0;
      forever begin
         @(negedge clk);
         if (spur_done != spur_cnt) begin
            donetx = 1'b1;
            @(negedge clk);
            donetx = 1'b0;
            spur_done++;
         end else if (newd === 1'b1 && rst === 1'b1) begin
            tx_busy = 1'b1;
            rc = rst_cnt;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            cap = dintx;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL tx_byte: got %0h, want nothing", cap);
            end else begin
               check("tx_byte", 32'(cap), 32'(exp_q.pop_front()));
            end
            sent_count++;
            repeat ($urandom_range(4, 12)) @(negedge clk);
            while (stall) @(negedge clk);
            if (rc == rst_cnt) begin
               check("newd_held", 32'(newd), 32'd1);
               check("dintx_stable", 32'(dintx), 32'(cap));
            end
            donetx = 1'b1;
            @(negedge clk);
            if (rc == rst_cnt) check("newd_gap", 32'(newd), 32'd0);
            @(negedge clk);
            donetx = 1'b0;
            @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   // Occupancy must never exceed the storage size
   always @(negedge clk) begin
      if (rst === 1'b1 && level > LW'(DEPTH)) begin
         total++;
         bad++;
         $display("FAIL level_bound: got %0d, max %0d", level, DEPTH);
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int base;
      logic [7:0] b;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_newd", 32'(newd), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef UART_TXQ_STATS_EN
      check("rst_tx_count", 32'(tx_count), 32'd0);
`endif

      // Single byte, exact push-to-newd latency
      base = sent_count;
      in_data  = 8'hA5;
      in_valid = 1'b1;
      check("a5_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(8'hA5);
      #1;
      in_valid = 1'b0;
      check("e0_level", 32'(level), 32'd1);
      check("e0_empty", 32'(empty), 32'd0);
      check("e0_newd", 32'(newd), 32'd0);
      @(posedge clk); #1;
      check("e1_level", 32'(level), 32'd0);
      check("e1_busy", 32'(busy), 32'd1);
      check("e1_newd", 32'(newd), 32'd0);
      @(posedge clk); #1;
      check("e2_newd", 32'(newd), 32'd1);
      check("e2_dintx", 32'(dintx), 32'hA5);
      wait_drain();
      check("a5_once", 32'(sent_count - base), 32'd1);

      // Spurious completion while idle
      base = sent_count;
`ifdef UART_TXQ_STATS_EN
      n = int'(tx_count);
`endif
      spur_cnt++;
      repeat (6) begin
         @(negedge clk);
         check("spur_newd", 32'(newd), 32'd0);
      end
      check("spur_busy", 32'(busy), 32'd0);
      check("spur_level", 32'(level), 32'd0);
      check("spur_empty", 32'(empty), 32'd1);
      check("spur_sent", 32'(sent_count - base), 32'd0);
`ifdef UART_TXQ_STATS_EN
      check("spur_tx_count", 32'(tx_count), 32'(n));
`endif

      // Burst to full: the lead byte occupies the stalled transmitter, 16 more fill the store
      stall = 1'b1;
      push_byte(8'hEE);
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      check("burst_full", 32'(full), 32'd1);
      check("burst_in_ready", 32'(in_ready), 32'd0);
      check("burst_level", 32'(level), 32'd16);
      in_data  = 8'h55;
      in_valid = 1'b1;
      repeat (4) begin
         check("refuse_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("refuse_level", 32'(level), 32'd16);
      stall = 1'b0;
      n = 0;
      while (full == 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("unfull_seen", 32'(full), 32'd0);
      check("unfull_ready", 32'(in_ready), 32'd1);
      check("unfull_level", 32'(level), 32'd15);
      wait_drain();
      check("burst_level0", 32'(level), 32'd0);
      check("burst_idle", 32'(busy), 32'd0);

      // Pointer wrap while draining
      for (int i = 0; i < 24; i++) begin
         push_byte(8'h10 + 8'(i));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain();

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         push_byte(b);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain();

      // Reset during SEND with three bytes still queued
      stall = 1'b1;
      base = sent_count;
      for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
      n = 0;
      while (!(sent_count != base && level == LW'(3)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("pre_rst_level", 32'(level), 32'd3);
      check("pre_rst_newd", 32'(newd), 32'd1);
      base = sent_count;
      exp_q.delete();
      rst_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_newd", 32'(newd), 32'd0);
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_empty", 32'(empty), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      stall = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (newd !== 1'b0) check("post_rst_newd", 32'(newd), 32'd0);
      end
      wait_drain();
      check("post_rst_sent", 32'(sent_count - base), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

`ifdef UART_TXQ_STATS_EN
      // Counter wrap from a preset value
      force dut.tx_count_r = 16'hFFFE;
      @(negedge clk);
      release dut.tx_count_r;
      @(negedge clk);
      check("preset_tx_count", 32'(tx_count), 32'h0000FFFE);
      for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i));
      wait_drain();
      check("wrap_tx_count", 32'(tx_count), 32'h00000001);
`endif

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
